// File: rtl/task_enq_arb.sv
// Round-robin enqueue arbiter: N cores compete to place a packed task into a
// one-entry registered output stage that feeds the downstream task unit.
module task_enq_arb #(
  parameter int N_CORES = 4,
  parameter int TASK_W  = 128,
  parameter int SLOT_W  = 7,
  parameter int CHILD_W = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_CORES-1:0]         in_valid,
  output logic [N_CORES-1:0]         in_ready,
  input  logic [N_CORES*TASK_W-1:0]  in_data,
  input  logic [N_CORES*SLOT_W-1:0]  in_slot,
  input  logic [N_CORES*CHILD_W-1:0] in_child,
  input  logic [N_CORES-1:0]         in_untied,
  input  logic [N_CORES-1:0]         in_flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TASK_W-1:0]          out_data,
  output logic [SLOT_W-1:0]          out_slot,
  output logic [CHILD_W-1:0]         out_child,
  output logic                       out_untied,
  output logic [$clog2(N_CORES)-1:0] out_core,
  output logic [31:0]                stat_enq,
  output logic [31:0]                stat_drop
);
  localparam int CORE_W = $clog2(N_CORES);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]         state_r;
  logic [CORE_W-1:0]  ptr_r;
  logic [CORE_W-1:0]  ptr_next_s;
  logic [CORE_W-1:0]  cidx_s;
  logic [CORE_W-1:0]  grant_idx_s;
  logic [N_CORES-1:0] eligible_s;
  logic               found_s;
  logic               load_en_s;
  logic               drop_s;
  logic               take_s;
  logic [TASK_W-1:0]  sel_data_s;
  logic [SLOT_W-1:0]  sel_slot_s;
  logic [CHILD_W-1:0] sel_child_s;
  logic               sel_untied_s;
  int                 idx_s;

  assign out_valid = (state_r == FULL);

  // Round-robin search from ptr_r: the first eligible core wins and its payload is selected.
  always_comb begin
    eligible_s   = in_valid & ~in_flush;
    found_s      = 1'b0;
    grant_idx_s  = '0;
    cidx_s       = '0;
    idx_s        = 0;
    sel_data_s   = '0;
    sel_slot_s   = '0;
    sel_child_s  = '0;
    sel_untied_s = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      idx_s = int'(ptr_r) + k;
      if (idx_s >= N_CORES) begin
        idx_s = idx_s - N_CORES;
      end else begin
        idx_s = idx_s;
      end
      cidx_s = CORE_W'(idx_s);
      if (!found_s && eligible_s[cidx_s]) begin
        found_s      = 1'b1;
        grant_idx_s  = cidx_s;
        sel_data_s   = in_data[idx_s*TASK_W +: TASK_W];
        sel_slot_s   = in_slot[idx_s*SLOT_W +: SLOT_W];
        sel_child_s  = in_child[idx_s*CHILD_W +: CHILD_W];
        sel_untied_s = in_untied[cidx_s];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Handshake qualification; a flush of the held task blocks loading for this cycle.
  always_comb begin
    load_en_s = (state_r == EMPTY) | out_ready;
    drop_s    = (state_r == FULL) & ~out_ready & in_flush[out_core];
    take_s    = found_s & load_en_s & ~drop_s & rstn;
    if (grant_idx_s == CORE_W'(N_CORES - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + 1'b1;
    end
  end

  // One-hot accept toward the granted core only.
  always_comb begin
    in_ready = '0;
    if (take_s) begin
      in_ready[grant_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output-stage state, arbitration pointer and statistics.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= EMPTY;
      ptr_r     <= '0;
      out_core  <= '0;
      stat_enq  <= 32'd0;
      stat_drop <= 32'd0;
    end else begin
      if ((state_r == FULL) && out_ready) begin
        stat_enq <= stat_enq + 32'd1;
      end
      if (drop_s) begin
        state_r   <= EMPTY;
        stat_drop <= stat_drop + 32'd1;
      end else if (take_s) begin
        state_r  <= FULL;
        out_core <= grant_idx_s;
        ptr_r    <= ptr_next_s;
      end else if (load_en_s) begin
        state_r <= EMPTY;
      end
    end
  end

  // Payload registers carry no reset; they are only meaningful while FULL.
  always_ff @(posedge clk) begin
    if (take_s) begin
      out_data   <= sel_data_s;
      out_slot   <= sel_slot_s;
      out_child  <= sel_child_s;
      out_untied <= sel_untied_s;
    end
  end
endmodule

// File: tb/tb_task_enq_arb.sv
// Self-checking bench for task_enq_arb: reference arbitration model plus a
// scoreboard of granted tasks compared when they leave the output stage.
module tb_task_enq_arb;
  localparam int N = 4;
  localparam int TW = 128;
  localparam int SW = 7;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [N*TW-1:0] in_data = '0;
  logic [N*SW-1:0] in_slot = '0;
  logic [N*CW-1:0] in_child = '0;
  logic [N-1:0]   in_untied = '0;
  logic [N-1:0]   in_flush = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [TW-1:0]  out_data;
  logic [SW-1:0]  out_slot;
  logic [CW-1:0]  out_child;
  logic           out_untied;
  logic [1:0]     out_core;
  logic [31:0]    stat_enq;
  logic [31:0]    stat_drop;

  task_enq_arb #(.N_CORES(N), .TASK_W(TW), .SLOT_W(SW), .CHILD_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_slot(in_slot), .in_child(in_child), .in_untied(in_untied),
    .in_flush(in_flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_slot(out_slot), .out_child(out_child),
    .out_untied(out_untied), .out_core(out_core),
    .stat_enq(stat_enq), .stat_drop(stat_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    core;
    logic [TW-1:0] data;
    logic [SW-1:0] slot;
    logic [CW-1:0] child;
    logic          untied;
  } item_t;

  item_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  logic        m_valid;
  int          m_core;
  int          m_ptr;
  logic [31:0] m_enq;
  logic [31:0] m_drop;

  task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_core = 0; m_ptr = 0; m_enq = 32'd0; m_drop = 32'd0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; in_valid = 4'b1111; in_flush = 4'b0000; out_ready = 1'b0;
    #1 check_val("rst_in_ready", TW'(in_ready), TW'(4'b0000));
    @(negedge clk);
    #1 check_val("rst_in_ready_hold", TW'(in_ready), TW'(4'b0000));
    @(negedge clk);
    rstn = 1'b1; in_valid = 4'b0000;
    #1;
    check_val("rst_out_valid", TW'(out_valid), TW'(1'b0));
    check_val("rst_out_core", TW'(out_core), TW'(2'd0));
    check_val("rst_stat_enq", TW'(stat_enq), TW'(32'd0));
    check_val("rst_stat_drop", TW'(stat_drop), TW'(32'd0));
    model_reset();
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] f, input logic r);
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    logic ld, drop;
    int gnt, idx;
    item_t it;
    @(negedge clk);
    in_valid = v; in_flush = f; out_ready = r;
    for (int i = 0; i < N; i++) begin
      in_data[i*TW +: TW] = {$urandom, $urandom, $urandom, $urandom};
      in_slot[i*SW +: SW] = SW'($urandom);
      in_child[i*CW +: CW] = CW'($urandom);
      in_untied[i] = 1'($urandom);
    end
    #1;
    elig = v & ~f;
    ld = !m_valid || r;
    drop = m_valid && !r && f[m_core];
    gnt = -1;
    if (ld && !drop) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (gnt < 0 && elig[idx]) gnt = idx;
      end
    end
    exp_rdy = (gnt >= 0) ? (4'b0001 << gnt) : 4'b0000;
    check_val("in_ready", TW'(in_ready), TW'(exp_rdy));
    check_val("out_valid", TW'(out_valid), TW'(m_valid));
    check_val("stat_enq", TW'(stat_enq), TW'(m_enq));
    check_val("stat_drop", TW'(stat_drop), TW'(m_drop));
    if (m_valid) begin
      if (sb.size() == 0) begin
        check_val("sb_empty", TW'(1'b1), TW'(1'b0));
      end else begin
        check_val("out_core", TW'(out_core), TW'(sb[0].core));
        check_val("out_data", out_data, sb[0].data);
        check_val("out_slot", TW'(out_slot), TW'(sb[0].slot));
        check_val("out_child", TW'(out_child), TW'(sb[0].child));
        check_val("out_untied", TW'(out_untied), TW'(sb[0].untied));
        if (r) begin
          void'(sb.pop_front()); m_enq = m_enq + 32'd1;
        end else if (drop) begin
          void'(sb.pop_front()); m_drop = m_drop + 32'd1;
        end
      end
    end
    if (drop) begin
      m_valid = 1'b0;
    end else if (gnt >= 0) begin
      it.core = 2'(gnt);
      it.data = in_data[gnt*TW +: TW];
      it.slot = in_slot[gnt*SW +: SW];
      it.child = in_child[gnt*CW +: CW];
      it.untied = in_untied[gnt];
      sb.push_back(it);
      m_valid = 1'b1; m_core = gnt; m_ptr = (gnt + 1) % N;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
  endtask

  initial begin
    logic [N-1:0] rv, rf;
    do_reset();

    // Full load, continuous drain: grants rotate 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) cyc(4'b1111, 4'b0000, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);
    #1 check_val("enq_after_8", TW'(stat_enq), TW'(32'd8));

    // Back-pressure: core 2 held for 5 cycles, then one transfer.
    do_reset();
    cyc(4'b0100, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) cyc(4'b1111, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b0);
    #1 check_val("bp_enq", TW'(stat_enq), TW'(32'd1));

    // Flush of the held task while stalled.
    do_reset();
    cyc(4'b0010, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0010, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b0);
    #1;
    check_val("flush_drop", TW'(stat_drop), TW'(32'd1));
    check_val("flush_enq", TW'(stat_enq), TW'(32'd0));

    // Flush coinciding with out_ready: transfer wins.
    do_reset();
    cyc(4'b0010, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0010, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b0);
    #1;
    check_val("race_enq", TW'(stat_enq), TW'(32'd1));
    check_val("race_drop", TW'(stat_drop), TW'(32'd0));

    // Request and flush on the same core in one cycle: no load.
    do_reset();
    cyc(4'b1000, 4'b1000, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);

    // Reset while FULL with a non-zero pointer, then lowest eligible wins.
    cyc(4'b0100, 4'b0000, 1'b0);
    do_reset();
    cyc(4'b0110, 4'b0000, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);

    // Random traffic with occasional flushes and stalls.
    for (int i = 0; i < 300; i++) begin
      rv = 4'($urandom);
      rf = ($urandom_range(0, 5) == 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      cyc(rv, rf, ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
